// File: rtl/uart_pkg.sv
// uart_pkg: action codes, parity modes and FSM states shared by the UART matrix receiver
package uart_pkg;
    localparam logic [3:0] ACT_CELL = 4'd2;
    localparam logic [3:0] ACT_ROW  = 4'd3;
    localparam logic [3:0] ACT_COL  = 4'd4;
    localparam logic [3:0] ACT_ALL  = 4'd5;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP, DRAIN} state_t;
endpackage

// File: rtl/uart_matrix_rx_frame.sv
// uart_frame_rx: one UART frame (start check, bit timing, data, parity, stop); UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 3,
    parameter int PAR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rx,
    input  logic         i_en,
    output logic         o_false,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_parity_err,
    output logic         o_frame_err,
    output logic         o_drained
);
    localparam int CW = $clog2(DIV);
    localparam int BW = W > 1 ? $clog2(W) : 1;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit;
    logic [W-1:0]  r_shift;
    logic          r_acc, r_perr;
    logic          w_smp, w_tick;
`ifdef UART_RX_MAJORITY_EN
    localparam int SMP     = DIV / 2 + 1;
    localparam int DIV_MIN = 4;
    logic [1:0] r_hist;
    // keep the two previous line samples so the vote sees DIV/2-1, DIV/2 and DIV/2+1
    always_ff @(posedge clk) r_hist <= rst ? 2'b11 : {r_hist[0], i_rx};
    assign w_smp = (r_hist[1] & r_hist[0]) | (r_hist[1] & i_rx) | (r_hist[0] & i_rx);
`else
    localparam int SMP     = DIV / 2;
    localparam int DIV_MIN = 3;
    assign w_smp = i_rx;
`endif
    if (DIV < DIV_MIN) begin : g_div_chk
        $error("uart_frame_rx: DIV below minimum for the selected sampling mode");
    end
    assign w_tick = r_cnt == CW'(SMP);
    assign o_data = r_shift;
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // frame sequencing and per-frame result strobes
    always_comb begin
        w_next       = r_state;
        o_false      = 1'b0;
        o_valid      = 1'b0;
        o_parity_err = 1'b0;
        o_frame_err  = 1'b0;
        o_drained    = 1'b0;
        case (r_state)
            IDLE:    w_next = (i_en && !i_rx) ? START : IDLE;
            START: if (w_tick) begin
                w_next  = w_smp ? IDLE : DATA;
                o_false = w_smp;
            end
            DATA:    if (w_tick && r_bit == BW'(W - 1)) w_next = (PAR != PAR_NONE) ? PARITY : STOP;
            PARITY:  if (w_tick) w_next = STOP;
            STOP: if (w_tick) begin
                w_next       = w_smp ? IDLE : DRAIN;
                o_frame_err  = !w_smp;
                o_parity_err = w_smp && r_perr;
                o_valid      = w_smp && !r_perr;
            end
            DRAIN: if (i_rx) begin
                w_next    = IDLE;
                o_drained = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end
    // bit timer restarts on the start edge; data shifts in LSB first with running parity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= CW'(1);
            r_bit   <= '0;
            r_shift <= '0;
            r_acc   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_cnt <= (r_state == IDLE) ? CW'(1) : (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + 1'b1;
            if (r_state == START) begin
                r_bit  <= '0;
                r_acc  <= 1'b0;
                r_perr <= 1'b0;
            end
            if (r_state == DATA && w_tick) begin
                r_shift <= {w_smp, r_shift[W-1:1]};
                r_acc   <= r_acc ^ w_smp;
                r_bit   <= r_bit + 1'b1;
            end
            if (r_state == PARITY && w_tick) r_perr <= w_smp != (r_acc ^ (PAR == PAR_ODD));
        end
    end
endmodule

// File: rtl/uart_matrix_rx.sv
// uart_matrix_rx: multi-frame UART receiver writing cell/row/column/all of a ROWS x COLS matrix with atomic commit (UART_RX_MAJORITY_EN passes to the frame receiver)
module uart_matrix_rx
    import uart_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIV     = 3,
    parameter int PAR     = 0,
    parameter int ROWS    = 2,
    parameter int COLS    = 4,
    parameter int GAP_MAX = 16,
    localparam int RW     = ROWS > 1 ? $clog2(ROWS) : 1,
    localparam int CLW    = COLS > 1 ? $clog2(COLS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    input  logic [RW-1:0]  row,
    input  logic [CLW-1:0] col,
    input  logic [3:0]     action,
    output logic [W-1:0]   r_cell,
    output logic           busy,
    output logic           done,
    output logic           err_parity,
    output logic           err_frame,
    output logic           err_timeout
);
    localparam int N  = ROWS * COLS;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int GW = $clog2(GAP_MAX * DIV);
    state_t r_state, w_next;
    logic [3:0]     r_act;
    logic [RW-1:0]  r_row;
    logic [CLW-1:0] r_col;
    logic [IW-1:0]  r_idx;
    logic [GW-1:0]  r_gcnt;
    logic           r_from_gap, r_done, r_err_p, r_err_f, r_err_t;
    logic [W-1:0]   r_stg [N];
    logic [W-1:0]   w_mat [ROWS][COLS];
    logic [W-1:0]   w_data;
    logic           w_act_ok, w_en, w_last, w_gap_exp;
    logic           w_false, w_valid, w_perr, w_ferr, w_drained;
    assign w_act_ok  = action >= ACT_CELL && action <= ACT_ALL;
    assign w_en      = (r_state == IDLE && w_act_ok) || r_state == GAP;
    assign w_gap_exp = r_gcnt == GW'(GAP_MAX * DIV - 1);
    assign w_last    = r_idx == (r_act == ACT_CELL ? IW'(0) : r_act == ACT_ROW ? IW'(COLS - 1) :
                                 r_act == ACT_COL ? IW'(ROWS - 1) : IW'(N - 1));
    assign busy        = r_state != IDLE;
    assign done        = r_done;
    assign err_parity  = r_err_p;
    assign err_frame   = r_err_f;
    assign err_timeout = r_err_t;
    assign r_cell      = w_mat[row][col];
    uart_frame_rx #(.W(W), .DIV(DIV), .PAR(PAR)) u_frame (
        .clk(clk), .rst(rst), .i_rx(rx), .i_en(w_en),
        .o_false(w_false), .o_valid(w_valid), .o_data(w_data),
        .o_parity_err(w_perr), .o_frame_err(w_ferr), .o_drained(w_drained)
    );
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // transaction sequencing; START covers a frame in flight inside the frame receiver
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!rx && w_act_ok) ? START : IDLE;
            START:   w_next = w_false ? (r_from_gap ? GAP : IDLE) : w_ferr ? DRAIN : w_perr ? IDLE :
                              w_valid ? (w_last ? IDLE : GAP) : START;
            GAP:     w_next = !rx ? START : w_gap_exp ? IDLE : GAP;
            DRAIN:   w_next = w_drained ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    // transaction setup, staging, gap timing and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_gcnt     <= '0;
            r_from_gap <= 1'b0;
            r_done     <= 1'b0;
            r_err_p    <= 1'b0;
            r_err_f    <= 1'b0;
            r_err_t    <= 1'b0;
            r_stg      <= '{default: '0};
        end else begin
            r_done <= r_state == START && w_valid && w_last;
            if (r_state == IDLE && w_next == START) begin
                r_act   <= action;
                r_row   <= row;
                r_col   <= col;
                r_idx   <= '0;
                r_err_p <= 1'b0;
                r_err_f <= 1'b0;
                r_err_t <= 1'b0;
            end
            if ((r_state == IDLE || r_state == GAP) && w_next == START) r_from_gap <= r_state == GAP;
            if (r_state == START && w_valid) begin
                r_stg[r_idx] <= w_data;
                r_idx        <= r_idx + 1'b1;
                r_gcnt       <= '0;
            end
            if (r_state == GAP) r_gcnt <= r_gcnt + 1'b1;
            if (w_perr) r_err_p <= 1'b1;
            if (w_ferr) r_err_f <= 1'b1;
            if (r_state == GAP && w_next == IDLE) r_err_t <= 1'b1;
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [W-1:0]  r_q;
            logic          w_hit;
            logic [IW-1:0] w_k;
            assign w_hit = r_act == ACT_CELL ? (r_row == RW'(r) && r_col == CLW'(c)) :
                           r_act == ACT_ROW ? r_row == RW'(r) : r_act == ACT_COL ? r_col == CLW'(c) : 1'b1;
            assign w_k   = r_act == ACT_CELL ? IW'(0) : r_act == ACT_ROW ? IW'(c) :
                           r_act == ACT_COL ? IW'(r) : IW'(r * COLS + c);
            // commit this cell from staging in the done cycle
            always_ff @(posedge clk) begin
                if (rst)                 r_q <= '0;
                else if (r_done && w_hit) r_q <= r_stg[w_k];
            end
            assign w_mat[r][c] = r_q;
        end
    end
endmodule

// File: tb/tb_uart_matrix_rx.sv
// tb_uart_matrix_rx: directed and randomized transactions against a matrix model
module tb_uart_matrix_rx;
    localparam int W = 8, DIV = 4, PAR = 1, ROWS = 2, COLS = 4, GAP_MAX = 16;
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [0:0] row = '0;
    logic [1:0] col = '0;
    logic [3:0] action = '0;
    logic [W-1:0] r_cell;
    logic busy, done, err_parity, err_frame, err_timeout;
    int errors = 0, checks = 0, done_cnt = 0;
    int exp_mat [ROWS][COLS];

    uart_matrix_rx #(.W(W), .DIV(DIV), .PAR(PAR), .ROWS(ROWS), .COLS(COLS), .GAP_MAX(GAP_MAX)) dut (
        .clk(clk), .rst(rst), .rx(rx), .row(row), .col(col), .action(action), .r_cell(r_cell),
        .busy(busy), .done(done), .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(stop_v);
    endtask

    task automatic check_mat(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                row = r[0:0];
                col = c[1:0];
                #1;
                check($sformatf("%s[%0d][%0d]", tag, r, c), r_cell, exp_mat[r][c]);
            end
    endtask

    task automatic check_flags(input string tag, input logic b, input logic p, input logic f, input logic t);
        check({tag, "_busy"}, busy, b);
        check({tag, "_errp"}, err_parity, p);
        check({tag, "_errf"}, err_frame, f);
        check({tag, "_errt"}, err_timeout, t);
    endtask

    task automatic run_txn(input string tag, input int a, input int r, input int c, input int bad, input int fixed);
        int n, d0, rr, cc;
        logic [W-1:0] data [ROWS*COLS];
        n = a == 2 ? 1 : a == 3 ? COLS : a == 4 ? ROWS : ROWS * COLS;
        d0 = done_cnt;
        action = a[3:0];
        row = r[0:0];
        col = c[1:0];
        for (int k = 0; k < n; k++) begin
            data[k] = fixed >= 0 ? W'(fixed + k) : W'($urandom);
            send_frame(data[k], k == bad, 1'b1);
            if (k == bad) break;
        end
        tick(3);
        if (bad < 0)
            for (int k = 0; k < n; k++) begin
                rr = a == 4 ? k : a == 5 ? k / COLS : r;
                cc = a == 3 ? k : a == 5 ? k % COLS : c;
                exp_mat[rr][cc] = data[k];
            end
        check({tag, "_done"}, done_cnt - d0, bad < 0 ? 1 : 0);
        check_flags(tag, 1'b0, bad >= 0, 1'b0, 1'b0);
        check_mat(tag);
    endtask

    initial begin
        int a, n, bad, d0;
        tick(3);
        check_flags("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("in_rst_done", done, 1'b0);
        rst = 1'b0;
        tick(2);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_mat("reset");

        run_txn("cell", 2, 1, 2, -1, 'hA5);
        run_txn("all", 5, 0, 0, -1, 1);
        run_txn("par_err", 3, 0, 0, 2, -1);

        d0 = done_cnt;
        action = 4'd2;
        row = 1'b0;
        col = 2'd0;
        send_frame(W'($urandom), 1'b0, 1'b0);
        tick(3 * DIV);
        check_flags("frame_hold", 1'b1, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        tick(2);
        check_flags("frame_end", 1'b0, 1'b0, 1'b1, 1'b0);
        check("frame_done", done_cnt - d0, 0);
        check_mat("frame");

        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        check("glitch_busy_early", busy, 1'b1);
        tick(2 * DIV);
        check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

        action = 4'd7;
        rx = 1'b0;
        tick(2 * DIV);
        check("bad_action_busy", busy, 1'b0);
        rx = 1'b1;
        tick(DIV);

        d0 = done_cnt;
        action = 4'd4;
        row = 1'b0;
        col = 2'd3;
        send_frame(8'h3C, 1'b0, 1'b1);
        tick(17 * DIV);
        check_flags("timeout", 1'b0, 1'b0, 1'b0, 1'b1);
        check("timeout_done", done_cnt - d0, 0);
        check_mat("timeout");

        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(2, 5);
            n = a == 2 ? 1 : a == 3 ? COLS : a == 4 ? ROWS : ROWS * COLS;
            bad = $urandom_range(0, 3) == 0 ? $urandom_range(0, n - 1) : -1;
            run_txn($sformatf("rnd%0d", i), a, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), bad, -1);
        end

        action = 4'd5;
        send_frame(W'($urandom), 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_mat[r][c] = 0;
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_mat("mid_rst");
        rst = 1'b0;
        rx = 1'b1;
        tick(2);
        run_txn("post_rst", 2, 1, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
